line_buffer_ctrl: RTL and testbench
===================================

Name: line_buffer_ctrl

Overview:
- Sequencer for one line_buffer_datapath instance. Generates its wr_en/rd_en so the buffer behaves as a DEPTH-pixel line delay, and supplies an output-valid strobe aligned to the datapath's registered data_o.
- Sits between the pixel-stream source and the window/kernel logic.
- Handles initial fill, steady-state streaming, stalls, and end-of-frame flush.
- Leaves the datapath's read and write pointers aligned at frame end, so frames run back to back with no datapath reset.

Parameters:
DEPTH, 1024, line length in pixels; must equal the datapath DEPTH.
CNT_W, 11, width of internal fill/flush counters; must hold the value DEPTH.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start_i  input  1  one-cycle pulse; begins a frame (honoured in IDLE only)
valid_i  input  1  incoming pixel valid (pixel data goes directly to the datapath data_i)
last_i  input  1  marks final pixel of frame; qualified by valid_i
wr_en_o  output  1  to datapath wr_en
rd_en_o  output  1  to datapath rd_en
valid_o  output  1  datapath data_o holds a valid delayed pixel this cycle
busy_o  output  1  high in any state other than IDLE
done_o  output  1  one-cycle pulse with the final valid_o of a frame

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE; all counters 0.
  - wr_en_o, rd_en_o, valid_o, busy_o, done_o = 0.
  - Reset mid-frame abandons the frame. The datapath shares rst_n, so its pointers realign as well.
- wr_en_o and rd_en_o are combinational from state, valid_i and counters: same-cycle response, no bubble.
- valid_o is rd_en_o registered one cycle, matching the datapath's one-cycle read latency. Its reset value is 0.
- IDLE:
  - wr/rd = 0; valid_i and last_i are ignored.
  - start_i -> FILL with fill_cnt=0.
- FILL:
  - wr_en_o = valid_i; rd_en_o = 0.
  - Each write increments fill_cnt.
  - A write with last_i -> FLUSH, flush_cnt = fill_cnt+1. Short-frame case: the frame is no longer than DEPTH.
  - Otherwise, a write that makes fill_cnt == DEPTH -> STREAM.
- STREAM:
  - wr_en_o = rd_en_o = valid_i. A simultaneous read and write hits the same address; the read returns the old (DEPTH-earlier) pixel.
  - valid_i=0 is a stall: no read, no write.
  - A write with last_i -> FLUSH, flush_cnt = DEPTH.
- FLUSH:
  - wr_en_o = 0; rd_en_o = 1 every cycle; valid_i, last_i and start_i are ignored.
  - flush_cnt decrements on each read.
  - Read with flush_cnt==1 -> DONE_WAIT.
- DONE_WAIT:
  - Single cycle. The final valid_o appears; done_o = 1 in the same cycle; next state IDLE.
- Invariants:
  - Total reads per frame equal total writes per frame.
  - Pointers are therefore equal in IDLE.
  - Number of valid_o cycles equals number of accepted pixels.
- start_i outside IDLE is ignored; no queuing.
- last_i without valid_i is ignored.
- A start_i arriving in the same cycle done_o is high is ignored. It is honoured one cycle later, in IDLE.

Decomposition:
- Shared package: state encoding localparams (IDLE, FILL, STREAM, FLUSH, DONE_WAIT; 3-bit) and a DEPTH-to-CNT_W width helper constant.
- Sub-module: the existing plus_1 incrementer (WIDTH=CNT_W) for fill_cnt.
- flush_cnt is a local down-counter. The FSM stays in this module.

Test Plan:
1. Full frame:
   - Stimulus: DEPTH=8, start_i, 20 back-to-back pixels 1..20, last_i on 20.
   - Response: wr_en_o high 20 cycles; rd_en_o first high with pixel 9.
   - Response: valid_o data sequence 1..20 (1..12 during STREAM, 13..20 during FLUSH); done_o high exactly once, with pixel 20.
2. Short frame:
   - Stimulus: DEPTH=8, 5 pixels 1..5, last_i on 5.
   - Response: no reads in FILL; FLUSH issues 5 reads; valid_o data 1..5; done_o once.
3. Stalls in STREAM:
   - Stimulus: DEPTH=8, 16 pixels with valid_i low for 3 cycles after pixel 10.
   - Response: wr_en_o and rd_en_o low in those 3 cycles; output order 1..16 unchanged; valid_o gap is 3 cycles.
4. Back-to-back frames:
   - Stimulus: DEPTH=8; frame A of 11 pixels, then start_i one cycle after done_o; frame B of 9 pixels 100..108.
   - Response: frame B output is exactly 100..108; no stale frame A data.
5. Reset mid-STREAM:
   - Stimulus: rst_n low during STREAM.
   - Response: all outputs 0 immediately and state IDLE; a subsequent 10-pixel frame outputs correctly.
6. Ignored inputs:
   - Stimulus: start_i, valid_i and last_i pulsed during FLUSH; last_i pulsed in IDLE.
   - Response: no extra wr_en_o; flush length unchanged; done_o count = 1.

Source files
------------

// File: rtl/line_buffer_ctrl_pkg.sv
// Shared definitions for the line-buffer sequencer: FSM state encoding and
// the helper that sizes the fill/flush counters from the line length.
package line_buffer_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FILL      = 3'd1,
        S_STREAM    = 3'd2,
        S_FLUSH     = 3'd3,
        S_DONE_WAIT = 3'd4
    } state_t;

    localparam int LBC_DEPTH_DEF = 1024;

    // Counters must be able to hold the value DEPTH itself, not just DEPTH-1.
    function automatic int lbc_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/line_buffer_ctrl_if.sv
// Handshake bundle between the pixel source/sink and the line-buffer sequencer.
interface line_buffer_ctrl_if;

    logic start_i;
    logic valid_i;
    logic last_i;
    logic wr_en_o;
    logic rd_en_o;
    logic valid_o;
    logic busy_o;
    logic done_o;

    modport master (
        output start_i, valid_i, last_i,
        input  wr_en_o, rd_en_o, valid_o, busy_o, done_o
    );

    modport slave (
        input  start_i, valid_i, last_i,
        output wr_en_o, rd_en_o, valid_o, busy_o, done_o
    );

endinterface

// File: rtl/line_buffer_ctrl_plus_1.sv
// Plain WIDTH-bit incrementer; wraps on overflow.
module line_buffer_ctrl_plus_1 #(
    parameter int WIDTH = 11
) (
    input  logic [WIDTH-1:0] i_a,
    output logic [WIDTH-1:0] o_y
);

    assign o_y = i_a + WIDTH'(1);

endmodule

// File: rtl/line_buffer_ctrl.sv
// Sequencer that drives a line_buffer_datapath as a DEPTH-pixel line delay,
// covering initial fill, streaming with stalls and end-of-frame flush.
module line_buffer_ctrl
    import line_buffer_ctrl_pkg::*;
#(
    parameter int DEPTH = LBC_DEPTH_DEF,
    parameter int CNT_W = lbc_cnt_w(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    line_buffer_ctrl_if.slave  bus
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_fill_cnt;
    logic [CNT_W-1:0]   w_fill_nxt;
    logic [CNT_W-1:0]   w_fill_inc;
    logic [CNT_W-1:0]   r_flush_cnt;
    logic [CNT_W-1:0]   w_flush_nxt;
    logic               w_wr_en;
    logic               w_rd_en;
    logic               r_valid;

    line_buffer_ctrl_plus_1 #(
        .WIDTH (CNT_W)
    ) u_fill_inc (
        .i_a (r_fill_cnt),
        .o_y (w_fill_inc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_fill_cnt  <= '0;
            r_flush_cnt <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fill_cnt  <= w_fill_nxt;
            r_flush_cnt <= w_flush_nxt;
            r_valid     <= w_rd_en;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill_cnt;
        w_flush_nxt = r_flush_cnt;
        w_wr_en     = 1'b0;
        w_rd_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start_i) begin
                    w_state_nxt = S_FILL;
                    w_fill_nxt  = '0;
                end
            end
            S_FILL: begin
                w_wr_en = bus.valid_i;
                if (bus.valid_i) begin
                    w_fill_nxt = w_fill_inc;
                    // A frame that ends before the line is full flushes only what it wrote.
                    if (bus.last_i) begin
                        w_state_nxt = S_FLUSH;
                        w_flush_nxt = w_fill_inc;
                    end else if (w_fill_inc == CNT_W'(DEPTH)) begin
                        w_state_nxt = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                w_wr_en = bus.valid_i;
                w_rd_en = bus.valid_i;
                if (bus.valid_i && bus.last_i) begin
                    w_state_nxt = S_FLUSH;
                    w_flush_nxt = CNT_W'(DEPTH);
                end
            end
            S_FLUSH: begin
                w_rd_en     = 1'b1;
                w_flush_nxt = r_flush_cnt - CNT_W'(1);
                if (r_flush_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_DONE_WAIT;
                end
            end
            S_DONE_WAIT: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.wr_en_o = w_wr_en;
    assign bus.rd_en_o = w_rd_en;
    assign bus.valid_o = r_valid;
    assign bus.busy_o  = (r_state != S_IDLE);
    assign bus.done_o  = (r_state == S_DONE_WAIT);

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl with a behavioural DEPTH=8 line-buffer datapath.
module tb_line_buffer_ctrl;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    line_buffer_ctrl_if lb ();

    line_buffer_ctrl #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (lb)
    );

    // Behavioural datapath: one-cycle registered read, read-before-write.
    logic [15:0] pix;
    logic [15:0] mem [0:DEPTH-1];
    logic [2:0]  wp;
    logic [2:0]  rp;
    logic [15:0] dout;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp   <= '0;
            rp   <= '0;
            dout <= '0;
        end else begin
            if (lb.wr_en_o) begin
                mem[wp] <= pix;
                wp      <= wp + 3'd1;
            end
            if (lb.rd_en_o) begin
                dout <= mem[rp];
                rp   <= rp + 3'd1;
            end
        end
    end

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int wr_cnt, rd_cnt, rdwr_cnt, done_cnt, done_vld, first_rd;
    int outq[$];
    int vtime[$];

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (lb.wr_en_o) wr_cnt++;
            if (lb.rd_en_o) begin
                rd_cnt++;
                if (lb.wr_en_o) rdwr_cnt++;
                if (first_rd < 0) first_rd = int'(pix);
            end
            if (lb.valid_o) begin
                outq.push_back(int'(dout));
                vtime.push_back(cyc);
            end
            if (lb.done_o) begin
                done_cnt++;
                if (lb.valid_o) done_vld++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        wr_cnt = 0; rd_cnt = 0; rdwr_cnt = 0; done_cnt = 0; done_vld = 0;
        first_rd = -1;
        outq.delete();
        vtime.delete();
    endtask

    task automatic wait_done();
        logic found;
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (lb.done_o) begin
                found = 1'b1;
                break;
            end
        end
        check("done_seen", {31'd0, found}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int n, input int base, input int stall_after,
                             input int stall_len, input bit noise);
        clear_stats();
        lb.start_i = 1'b1;
        @(posedge clk); #1;
        lb.start_i = 1'b0;
        for (int i = 1; i <= n; i++) begin
            lb.valid_i = 1'b1;
            pix        = 16'(base + i - 1);
            lb.last_i  = (i == n);
            @(posedge clk); #1;
            if (i == stall_after) begin
                lb.valid_i = 1'b0;
                lb.last_i  = 1'b0;
                repeat (stall_len) @(posedge clk);
                #1;
            end
        end
        lb.valid_i = 1'b0;
        lb.last_i  = 1'b0;
        if (noise) begin
            @(posedge clk); #1;
            lb.start_i = 1'b1; lb.valid_i = 1'b1; lb.last_i = 1'b1;
            @(posedge clk); #1;
            lb.start_i = 1'b0; lb.valid_i = 1'b0; lb.last_i = 1'b0;
        end
        wait_done();
    endtask

    task automatic check_seq(input string tag, input int n, input int base);
        check({tag, "_count"}, outq.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < outq.size()) check({tag, "_data"}, outq[i], base + i);
        end
    endtask

    initial begin
        lb.start_i = 1'b0;
        lb.valid_i = 1'b1;
        lb.last_i  = 1'b0;
        pix        = '0;
        clear_stats();

        // Reset state, with valid_i held high to show it is ignored
        #12;
        check("rst_wr_en", lb.wr_en_o, 0);
        check("rst_rd_en", lb.rd_en_o, 0);
        check("rst_valid", lb.valid_o, 0);
        check("rst_busy",  lb.busy_o,  0);
        check("rst_done",  lb.done_o,  0);
        lb.valid_i = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: full frame of 20
        run_frame(20, 1, 0, 0, 1'b0);
        check("t1_wr_cnt",   wr_cnt, 20);
        check("t1_first_rd", first_rd, 9);
        check("t1_rd_cnt",   rd_cnt, 20);
        check("t1_stream_rd", rdwr_cnt, 12);
        check_seq("t1", 20, 1);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_done_vld", done_vld, 1);
        check("t1_busy_end", lb.busy_o, 0);
        check("t1_ptr_eq", {29'd0, wp}, {29'd0, rp});

        // 2: short frame of 5
        run_frame(5, 1, 0, 0, 1'b0);
        check("t2_fill_rd", rdwr_cnt, 0);
        check("t2_rd_cnt",  rd_cnt, 5);
        check_seq("t2", 5, 1);
        check("t2_done_cnt", done_cnt, 1);
        check("t2_ptr_eq", {29'd0, wp}, {29'd0, rp});

        // 3: 3-cycle stall after pixel 10
        run_frame(16, 1, 10, 3, 1'b0);
        check("t3_wr_cnt", wr_cnt, 16);
        check("t3_stream_rd", rdwr_cnt, 8);
        check("t3_rd_cnt", rd_cnt, 16);
        check_seq("t3", 16, 1);
        if (vtime.size() > 2) check("t3_gap", vtime[2] - vtime[1] - 1, 3);
        else check("t3_gap_len", vtime.size(), 16);

        // 4: back-to-back frames, B starts the cycle after done
        run_frame(11, 1, 0, 0, 1'b0);
        check_seq("t4a", 11, 1);
        run_frame(9, 100, 0, 0, 1'b0);
        check_seq("t4b", 9, 100);
        check("t4b_done_cnt", done_cnt, 1);
        check("t4_ptr_eq", {29'd0, wp}, {29'd0, rp});

        // 5: reset during STREAM
        clear_stats();
        lb.start_i = 1'b1;
        @(posedge clk); #1;
        lb.start_i = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            lb.valid_i = 1'b1;
            pix = 16'(i);
            @(posedge clk); #1;
        end
        check("t5_pre_rd", lb.rd_en_o, 1);
        rst_n = 1'b0;
        #1;
        check("t5_wr_en", lb.wr_en_o, 0);
        check("t5_rd_en", lb.rd_en_o, 0);
        check("t5_valid", lb.valid_o, 0);
        check("t5_busy",  lb.busy_o,  0);
        check("t5_done",  lb.done_o,  0);
        lb.valid_i = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(10, 50, 0, 0, 1'b0);
        check_seq("t5", 10, 50);
        check("t5_done_cnt", done_cnt, 1);

        // 6: start/valid/last during FLUSH, last in IDLE
        run_frame(12, 1, 0, 0, 1'b1);
        check("t6_wr_cnt", wr_cnt, 12);
        check("t6_rd_cnt", rd_cnt, 12);
        check_seq("t6", 12, 1);
        check("t6_done_cnt", done_cnt, 1);
        clear_stats();
        lb.valid_i = 1'b1; lb.last_i = 1'b1; pix = 16'd77;
        @(posedge clk); #1;
        lb.valid_i = 1'b0; lb.last_i = 1'b0;
        @(posedge clk); #1;
        check("t6_idle_wr", wr_cnt, 0);
        check("t6_idle_busy", lb.busy_o, 0);
        check("t6_ptr_eq", {29'd0, wp}, {29'd0, rp});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
